// File: rtl/win_avg.sv
// win_avg: per-lane sliding-window mean over the last N accepted samples, Q(bits).(bits) output
module win_avg #(
   parameter int numbers = 10,
   parameter int streams = 16,
   parameter int bits = 2
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [4:0]                  win_len,
   input  logic [bits*streams-1:0]     axis_di,
   input  logic                        axis_vi,
   output logic                        axis_ri,
   output logic [2*bits*streams-1:0]   axis_do,
   output logic                        axis_vo,
   input  logic                        axis_ro
);
   localparam int aw = bits + $clog2(numbers) + 1;
   localparam int nw = aw + bits;
   localparam int ow = 2 * bits;
   logic signed [bits-1:0] hist [streams][numbers];
   logic [4:0] fill, neff, n;
   logic [5:0] fill_inc;
   logic [ow*streams-1:0] res;
   logic acc;
   assign axis_ri = !axis_vo || axis_ro;
   assign acc = axis_vi && axis_ri;
   always_comb begin
      neff = win_len == 5'd0 ? 5'd1 : win_len > 5'(numbers) ? 5'(numbers) : win_len;
      fill_inc = {1'b0, fill} + 6'd1;
      n = {1'b0, neff} < fill_inc ? neff : fill_inc[4:0];
   end
   for (genvar g = 0; g < streams; g++) begin : lane
      logic signed [aw-1:0] sum;
      logic signed [nw-1:0] num, den, q, r, fl;
      always_comb begin
         sum = aw'($signed(axis_di[g*bits +: bits]));
         for (int i = 0; i < numbers - 1; i++)
            if (i < int'(n) - 1) sum = sum + aw'(hist[g][i]);
         num = nw'(sum) <<< bits;
         den = nw'($signed({1'b0, n}));
         q = num / den;
         r = num % den;
         fl = (r != '0 && num[nw-1]) ? q - nw'(1) : q;
      end
      assign res[g*ow +: ow] = fl[nw-1:ow-1] == {(nw-ow+1){fl[nw-1]}} ? fl[ow-1:0]
                             : {fl[nw-1], {(ow-1){!fl[nw-1]}}};
   end
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         for (int s = 0; s < streams; s++)
            for (int i = 0; i < numbers; i++) hist[s][i] <= '0;
         fill <= '0;
         axis_vo <= 1'b0;
         axis_do <= '0;
      end else if (acc) begin
         for (int s = 0; s < streams; s++) begin
            hist[s][0] <= axis_di[s*bits +: bits];
            for (int i = 1; i < numbers; i++) hist[s][i] <= hist[s][i-1];
         end
         fill <= fill < 5'(numbers) ? fill + 5'd1 : fill;
         axis_do <= res;
         axis_vo <= 1'b1;
      end else if (axis_ro) axis_vo <= 1'b0;
   end
endmodule

// File: tb/tb_win_avg.sv
// tb_win_avg: directed vectors with a queued scoreboard checked by an independent output monitor
module tb_win_avg;
   logic aclk, aresetn, axis_vi, axis_ri, axis_vo, axis_ro;
   logic [4:0] win_len;
   logic [31:0] axis_di;
   logic [63:0] axis_do;
   logic [63:0] exp_q [$];
   int total = 0;
   int passed = 0;
   win_avg dut (
      .aclk(aclk), .aresetn(aresetn), .win_len(win_len),
      .axis_di(axis_di), .axis_vi(axis_vi), .axis_ri(axis_ri),
      .axis_do(axis_do), .axis_vo(axis_vo), .axis_ro(axis_ro)
   );
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;
   function automatic logic [31:0] pk(input logic [1:0] a, input logic [1:0] b);
      pk = {{15{b}}, a};
   endfunction
   function automatic logic [63:0] ex(input logic [3:0] a, input logic [3:0] b);
      ex = {{15{b}}, a};
   endfunction
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask
   always @(negedge aclk) begin
      #1;
      if (aresetn && axis_vo && axis_ro) begin
         if (exp_q.size() == 0) chk("extra_beat", 64'(exp_q.size()), 64'd1);
         else chk("beat", axis_do, exp_q.pop_front());
      end
   end
   task automatic send(input logic [31:0] di, input logic [4:0] wl, input logic [63:0] e);
      int t = 0;
      axis_di = di;
      win_len = wl;
      axis_vi = 1'b1;
      while (!axis_ri && t < 50) begin
         @(negedge aclk);
         t++;
      end
      if (!axis_ri) chk("send_timeout", 64'(axis_ri), 64'd1);
      exp_q.push_back(e);
      @(negedge aclk);
   endtask
   task automatic rst_seq();
      axis_vi = 1'b0;
      @(negedge aclk);
      aresetn = 1'b0;
      exp_q.delete();
      @(negedge aclk);
      chk("rst_vo", 64'(axis_vo), 64'd0);
      chk("rst_do", axis_do, 64'd0);
      aresetn = 1'b1;
   endtask
   initial begin
      int t;
      aresetn = 1'b0;
      axis_vi = 1'b0;
      axis_ro = 1'b1;
      win_len = 5'd0;
      axis_di = '0;
      repeat (2) @(negedge aclk);
      chk("init_vo", 64'(axis_vo), 64'd0);
      chk("init_do", axis_do, 64'd0);
      aresetn = 1'b1;
      send(pk(2'b11, 2'b01), 5'd1, ex(4'hC, 4'h4));
      rst_seq();
      repeat (6) send(pk(2'b01, 2'b01), 5'd4, ex(4'h4, 4'h4));
      send(pk(2'b11, 2'b11), 5'd4, ex(4'h2, 4'h2));
      send(pk(2'b11, 2'b11), 5'd4, ex(4'h0, 4'h0));
      send(pk(2'b11, 2'b11), 5'd4, ex(4'hE, 4'hE));
      send(pk(2'b11, 2'b11), 5'd4, ex(4'hC, 4'hC));
      rst_seq();
      send(pk(2'b01, 2'b01), 5'd2, ex(4'h4, 4'h4));
      send(pk(2'b11, 2'b01), 5'd2, ex(4'h0, 4'h4));
      send(pk(2'b01, 2'b01), 5'd2, ex(4'h0, 4'h4));
      send(pk(2'b11, 2'b01), 5'd2, ex(4'h0, 4'h4));
      rst_seq();
      send(pk(2'b01, 2'b00), 5'd3, ex(4'h4, 4'h0));
      send(pk(2'b01, 2'b00), 5'd3, ex(4'h4, 4'h0));
      send(pk(2'b00, 2'b00), 5'd3, ex(4'h2, 4'h0));
      send(pk(2'b11, 2'b01), 5'd0, ex(4'hC, 4'h4));
      rst_seq();
      repeat (10) send(pk(2'b01, 2'b01), 5'd20, ex(4'h4, 4'h4));
      send(pk(2'b00, 2'b00), 5'd20, ex(4'h3, 4'h3));
      rst_seq();
      send(pk(2'b11, 2'b00), 5'd3, ex(4'hC, 4'h0));
      send(pk(2'b00, 2'b00), 5'd3, ex(4'hE, 4'h0));
      send(pk(2'b00, 2'b00), 5'd3, ex(4'hE, 4'h0));
      send(pk(2'b10, 2'b10), 5'd1, ex(4'h8, 4'h8));
      rst_seq();
      axis_ro = 1'b0;
      axis_di = pk(2'b01, 2'b01);
      win_len = 5'd1;
      axis_vi = 1'b1;
      exp_q.push_back(ex(4'h4, 4'h4));
      @(negedge aclk);
      axis_di = pk(2'b11, 2'b11);
      for (int i = 0; i < 4; i++) begin
         chk("bp_ri", 64'(axis_ri), 64'd0);
         chk("bp_vo", 64'(axis_vo), 64'd1);
         chk("bp_do", axis_do, ex(4'h4, 4'h4));
         @(negedge aclk);
      end
      exp_q.push_back(ex(4'hC, 4'hC));
      axis_ro = 1'b1;
      @(negedge aclk);
      send(pk(2'b01, 2'b01), 5'd3, ex(4'h1, 4'h1));
      rst_seq();
      repeat (3) send(pk(2'b01, 2'b01), 5'd5, ex(4'h4, 4'h4));
      aresetn = 1'b0;
      axis_vi = 1'b0;
      axis_ro = 1'b0;
      exp_q.delete();
      @(negedge aclk);
      chk("mid_rst_vo", 64'(axis_vo), 64'd0);
      chk("mid_rst_do", axis_do, 64'd0);
      chk("mid_rst_ri", 64'(axis_ri), 64'd1);
      aresetn = 1'b1;
      axis_ro = 1'b1;
      send(pk(2'b10, 2'b01), 5'd5, ex(4'h8, 4'h4));
      axis_vi = 1'b0;
      t = 0;
      while (exp_q.size() != 0 && t < 20) begin
         @(negedge aclk);
         t++;
      end
      @(negedge aclk);
      chk("drain", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/win_avg.md
Name: win_avg

Overview:
- Per-stream sliding-window averager for packed multi-stream AXI-Stream sample words (e.g. DOA snapshot pre-filtering).
- Each accepted beat carries `streams` signed samples of `bits` width.
- The block emits, per stream, the mean of the last N accepted samples as a signed fixed-point value of width 2*bits with `bits` fractional bits.
- N is runtime-selectable via win_len, up to `numbers`.

Parameters:
- numbers, 10, maximum window depth (history length per stream); 1..31
- streams, 16, number of independent sample lanes per beat
- bits, 2, width of each signed input sample; output lanes are 2*bits wide

Ports:
- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  synchronous active-low reset
- win_len  in  5  requested window length N (unsigned)
- axis_di  in  bits*streams  input samples; lane s = axis_di[s*bits +: bits], two's complement
- axis_vi  in  1  input valid
- axis_ri  out  1  input ready (DUT to upstream)
- axis_do  out  2*bits*streams  output means; lane s = axis_do[s*2*bits +: 2*bits]
- axis_vo  out  1  output valid
- axis_ro  in  1  output ready (downstream to DUT)

Behaviour:
- One clock domain, aclk.
- Synchronous active-low reset aresetn: clears all history registers and the fill counter, and forces axis_vo=0 and axis_do=0.
- Reset asserted mid-transfer discards any pending output beat.
- Effective window: Neff = clamp(win_len, 1, numbers); win_len=0 is treated as 1, and win_len>numbers is treated as numbers.
- Sampling win_len: it is sampled on each accepted beat; a change affects only beats accepted from then on. History is retained across changes.
- History:
  - Per lane, a shift register of depth `numbers` holds the most recent accepted samples.
  - fill = number of accepted beats since reset, saturating at numbers.
- Window length per beat: for an accepted beat, N = min(Neff, fill including the current beat). The window is never padded with zeros.
- Arithmetic per lane:
  - sum = signed sum of the last N samples, including the current one; accumulator width ≥ bits+ceil(log2(numbers))+1.
  - out = floor(sum * 2^bits / N), computed exactly (floor toward −inf) and saturated to the signed 2*bits range.
  - Result format: Q(bits).(bits). Example with bits=2: sample 1 -> 4'h4, sample -1 -> 4'hC.
- Handshake:
  - Beat accepted when axis_vi && axis_ri.
  - axis_ri = !axis_vo || axis_ro.
  - Output register: on accept, axis_do is loaded with the result and axis_vo=1 on the next rising edge (latency 1 cycle).
  - axis_vo is cleared after axis_vo && axis_ro unless a new beat is accepted in the same cycle. Simultaneous consume and accept keeps axis_vo=1 with the new data, giving full throughput.
  - While axis_vo && !axis_ro: axis_do and axis_vo hold stable, axis_ri=0, and history does not advance.
- axis_vi low: no state change; axis_do holds its last value.
- Implementation freedom: an internal pipeline deeper than 1 is not permitted. The division must be combinational, e.g. via a reciprocal LUT with a correction step, and must give the exact floor result for all reachable sums.

Test Plan:
- Reset, win_len=1, axis_ro=1, axis_di lane0=2'b11 (−1), lanes1..15=2'b01 -> after 1 cycle axis_vo=1, lane0=4'hC, lanes1..15=4'h4.
- win_len=4, constant 1 on all lanes for 6 beats -> every output lane 4'h4. Then switch to −1 -> outputs −0.25·… floor sequence 4'h2, 4'h0, 4'hE, 4'hC (sum·4/4 floor for sums 2, 0, −2, −4).
- win_len=2, alternating 1, −1 on lane 0 -> outputs 4'h4 (fill=1), then 4'h0, 4'h0, …
- win_len=3, lane0 = 1, 1, 0 -> 4'h4, 4'h4, floor(8/3)=4'h2; win_len=0 behaves as 1; win_len=20 behaves as 10 (after 10 beats of 1 then 0, output floor(36/10)=4'h3).
- Backpressure: axis_ro=0 with axis_vi=1 continuous -> exactly one beat accepted, axis_ri=0 and axis_do stable until axis_ro=1; no samples lost or duplicated.
- Assert aresetn=0 mid-stream -> next cycle axis_vo=0, axis_do=0, fill restarts (first output after reset = sample·4).
